// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the ROM (slave).
// The ROM answers combinationally in the same cycle as the address.
interface inst_fetch_unit_if;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic [31:0] rom_data_i;

    modport master (
        output rom_addr_o,
        output rom_ce_o,
        input  rom_data_i
    );

    modport slave (
        input  rom_addr_o,
        input  rom_ce_o,
        output rom_data_i
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: program counter, ROM drive and IF/ID register.
// Define FETCH_PERF_CNT_EN to add fetch and stall performance counters.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    inst_fetch_unit_if.master         rom_if,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [31:0]               new_pc_i,
    input  logic                      branch_flag_i,
    input  logic [31:0]               branch_target_i,
    output logic [31:0]               if_pc_o,
    output logic [31:0]               if_inst_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]               fetch_cnt_o,
    output logic [31:0]               stall_cnt_o,
`endif
    output logic                      if_valid_o
);

    logic [31:0] pc_q, pc_d;
    logic        ce_q;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic        load_word;

    // Redirect priority: flush beats stall, stall beats branch. A stalled
    // branch is dropped; ID re-asserts it once the stall releases.
    always_comb begin
        pc_d = pc_q;
        if (ce_q) begin
            if (flush_i)            pc_d = new_pc_i;
            else if (stall_i)       pc_d = pc_q;
            else if (branch_flag_i) pc_d = branch_target_i;
            else                    pc_d = pc_q + PC_STEP;
        end
    end

    assign load_word = ce_q && !flush_i && !stall_i;

    // The word fetched alongside a taken branch is the delay slot and is kept.
    always_comb begin
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        if (flush_i) begin
            if_pc_d    = '0;
            if_inst_d  = '0;
            if_valid_d = 1'b0;
        end else if (stall_i) begin
            if_valid_d = if_valid_q;
        end else if (ce_q) begin
            if_pc_d    = pc_q;
            if_inst_d  = rom_if.rom_data_i;
            if_valid_d = 1'b1;
        end else begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            ce_q       <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ce_q       <= 1'b1;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign rom_if.rom_addr_o = pc_q;
    assign rom_if.rom_ce_o   = ce_q;
    assign if_pc_o           = if_pc_q;
    assign if_inst_o         = if_inst_q;
    assign if_valid_o        = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, load_word};
        stall_cnt_d = stall_cnt_q + {31'd0, (stall_i && ce_q)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_load_word;
    assign unused_load_word = load_word;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a combinational ROM model and an
// expected-IF/ID queue filled as each step is driven.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    int n_cmp;
    int n_fail;
    logic [64:0] exp_q[$];

    inst_fetch_unit_if rom_if ();

    inst_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_if          (rom_if.master),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o),
`endif
        .if_valid_o      (if_valid_o)
    );

    // Clock and ROM model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: rom_word = 32'h3401_8000;
            32'h0000_0004: rom_word = 32'h0001_0c00;
            default:       rom_word = addr ^ 32'hDEAD_0000;
        endcase
    endfunction

    assign rom_if.rom_data_i = rom_if.rom_ce_o ? rom_word(rom_if.rom_addr_o) : 32'h0;

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_ce"},    {31'd0, rom_if.rom_ce_o}, 32'd0);
        check({tag, "_addr"},  rom_if.rom_addr_o, 32'h0);
        check({tag, "_valid"}, {31'd0, if_valid_o}, 32'd0);
        check({tag, "_pc"},    if_pc_o, 32'h0);
        check({tag, "_inst"},  if_inst_o, 32'h0);
    endtask

    // Push the expected IF/ID contents, clock once, then pop and compare.
    task automatic step(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] addr);
        logic [64:0] e;
        exp_q.push_back({v, pc, (v ? rom_word(pc) : 32'h0)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_valid"}, {31'd0, if_valid_o}, {31'd0, e[64]});
        check({tag, "_pc"},    if_pc_o, e[63:32]);
        check({tag, "_inst"},  if_inst_o, e[31:0]);
        check({tag, "_addr"},  rom_if.rom_addr_o, addr);
        check({tag, "_ce"},    {31'd0, rom_if.rom_ce_o}, 32'd1);
    endtask

    task automatic drive(input logic st, input logic fl, input logic [31:0] npc,
                         input logic br, input logic [31:0] tgt);
        stall_i         = st;
        flush_i         = fl;
        new_pc_i        = npc;
        branch_flag_i   = br;
        branch_target_i = tgt;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_zero_state("reset");
        rst_n = 1'b1;

        // Start-up latency
        step("rel_e1", 1'b0, 32'h0, 32'h0);
        step("rel_e2", 1'b1, 32'h0, 32'h4);
        step("rel_e3", 1'b1, 32'h4, 32'h8);

        // Three-cycle stall at pc=0x8
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 32'h4, 32'h8);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("resume8", 1'b1, 32'h8, 32'hC);
        step("resumeC", 1'b1, 32'hC, 32'h10);

        // Branch with delay slot at pc=0x40
        drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        step("fl40", 1'b0, 32'h0, 32'h40);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h4C);
        step("dslot", 1'b1, 32'h40, 32'h4C);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("tgt4C", 1'b1, 32'h4C, 32'h50);

        // Stall beats branch; branch honoured on re-assertion
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        step("stbr", 1'b1, 32'h4C, 32'h50);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        step("br80", 1'b1, 32'h50, 32'h80);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("tgt80", 1'b1, 32'h80, 32'h84);

        // Flush beats stall and branch
        drive(1'b1, 1'b1, 32'h60, 1'b1, 32'h90);
        step("flall", 1'b0, 32'h0, 32'h60);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("ld60", 1'b1, 32'h60, 32'h64);

        // PC wrap
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step("flwrap", 1'b0, 32'h0, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0);
        step("wrap0", 1'b1, 32'h0, 32'h4);

        // Unaligned target passes through unmasked
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
        step("unal", 1'b1, 32'h4, 32'h102);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("unal2", 1'b1, 32'h102, 32'h106);

        // Asynchronous reset at pc=0x24
        drive(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        step("fl20", 1'b0, 32'h0, 32'h20);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("ld20", 1'b1, 32'h20, 32'h24);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_pre", fetch_cnt_o, 32'd14);
        check("stall_cnt_pre", stall_cnt_o, 32'd5);
`endif
        rst_n = 1'b0;
        #1;
        check_zero_state("async_rst");
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_rst", fetch_cnt_o, 32'd0);
        check("stall_cnt_rst", stall_cnt_o, 32'd0);
`endif
        @(posedge clk);
        #1;
        check_zero_state("rst_hold");
        rst_n = 1'b1;
        step("re_e1", 1'b0, 32'h0, 32'h0);
        step("re_e2", 1'b1, 32'h0, 32'h4);
        step("re_e3", 1'b1, 32'h4, 32'h8);
        step("re_e4", 1'b1, 32'h8, 32'hC);
        step("re_e5", 1'b1, 32'hC, 32'h10);
        step("re_e6", 1'b1, 32'h10, 32'h14);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_post", fetch_cnt_o, 32'd5);
        check("stall_cnt_post", stall_cnt_o, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
